// File: rtl/card_shuffler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : card_shuffler                                                |
// | Description : Builds the card layout for one round of the memory game.     |
// |               N_CARDS/2 colour pairs are spread over N_CARDS slots with a  |
// |               Fisher-Yates shuffle fed by a free-running 16-bit LFSR.      |
// |               Handshake: level request compute_colors_en, answer           |
// |               compute_done held until the request falls.                   |
// |               Optional macro FIXED_LAYOUT_EN skips the shuffle and returns |
// |               the sorted layout (bring-up / deterministic debug).          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module card_shuffler #(
   parameter int          N_CARDS   = 16,
   parameter int          IDX_W     = 4,
   parameter int          COLOR_W   = 3,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       compute_colors_en,
   output logic                       compute_done,
   output logic [N_CARDS*COLOR_W-1:0] card_colors
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_INIT    = 2'd1,
      ST_SHUFFLE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t             r_state;
   logic [15:0]        r_lfsr;
   logic               r_en_q;
   logic [IDX_W-1:0]   r_i;
   logic [1:0]         r_rej;
   logic               r_done;
   logic [COLOR_W-1:0] r_bank [N_CARDS];

   logic               w_fb;
   logic [IDX_W-1:0]   w_j;
   logic               w_start;
   logic               w_j_ok;
   logic               w_accept;
   logic               w_last;

   // Fibonacci feedback for x^16+x^14+x^13+x^11+1 (right-shifting form)
   assign w_fb     = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
   // Candidate swap partner comes straight from the low LFSR bits
   assign w_j      = r_lfsr[IDX_W-1:0];
   assign w_start  = compute_colors_en & ~r_en_q;
   assign w_j_ok   = (w_j <= r_i);
   // Three rejections in a row force an accept so latency stays bounded
   assign w_accept = w_j_ok | (r_rej == 2'd3);
   assign w_last   = (r_i == IDX_W'(1));

   // LFSR runs every cycle in every state; request timing provides entropy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= {w_fb, r_lfsr[15:1]};
      end
   end

   // Registered sample of the request for rising-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_en_q <= 1'b0;
      end else begin
         r_en_q <= compute_colors_en;
      end
   end

   // Control FSM with the colour bank and registered done flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
         r_i     <= '0;
         r_rej   <= '0;
         for (int k = 0; k < N_CARDS; k++) begin
            r_bank[k] <= '0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (w_start) begin
                  r_state <= ST_INIT;
               end
            end

            ST_INIT: begin
               if (!compute_colors_en) begin
                  r_state <= ST_IDLE;
               end else begin
                  // Sorted pairs 0,0,1,1,... as the shuffle starting point
                  for (int k = 0; k < N_CARDS; k++) begin
                     r_bank[k] <= COLOR_W'(k / 2);
                  end
                  r_i   <= IDX_W'(N_CARDS - 1);
                  r_rej <= '0;
`ifdef FIXED_LAYOUT_EN
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
`else
                  r_state <= ST_SHUFFLE;
`endif
               end
            end

            ST_SHUFFLE: begin
               if (!compute_colors_en) begin
                  // Abort: partial bank is still a permutation of the pairs
                  r_state <= ST_IDLE;
               end else if (w_accept) begin
                  // Forced accepts leave the slot in place (j treated as i)
                  if (w_j_ok) begin
                     r_bank[r_i] <= r_bank[w_j];
                     r_bank[w_j] <= r_bank[r_i];
                  end
                  r_i   <= r_i - IDX_W'(1);
                  r_rej <= '0;
                  if (w_last) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_rej <= r_rej + 2'd1;
               end
            end

            ST_DONE: begin
               if (!compute_colors_en) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign compute_done = r_done;

   // Flatten the bank, card 0 in the least significant bits
   for (genvar g = 0; g < N_CARDS; g++) begin : g_pack
      assign card_colors[g*COLOR_W +: COLOR_W] = r_bank[g];
   end

endmodule
`default_nettype wire

// File: tb/tb_card_shuffler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_card_shuffler                                             |
// | Description : Self-checking bench for card_shuffler. A reference model     |
// |               predicts layout and done latency from the LFSR state at the  |
// |               request; predictions go through a scoreboard queue.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_card_shuffler;

   localparam int N  = 16;
   localparam int CW = 3;
   localparam int LW = N * CW;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          done;
   logic [LW-1:0] colors;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [LW-1:0] layout;
      int            done_edge;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int gap;
      int hold;
   } vec_t;

   always #5 clk = ~clk;

   card_shuffler dut (
      .clk               (clk),
      .rst               (rst),
      .compute_colors_en (en),
      .compute_done      (done),
      .card_colors       (colors)
   );

   function automatic logic [15:0] step(input logic [15:0] v);
      return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
   endfunction

   // Reference LFSR, tracks the value the DUT holds between edges
   logic [15:0] m_lfsr;
   always @(posedge clk or posedge rst) begin
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= step(m_lfsr);
   end

   // Edge 0 = request edge, edge 1 = INIT, edges 2.. = shuffle attempts
   function automatic void model(input logic [15:0] l0, output logic [LW-1:0] lay,
                                 output int dedge, output bit forced1);
      logic [CW-1:0] b [N];
      logic [15:0]   l;
      logic [3:0]    j;
      logic [CW-1:0] t;
      int            i;
      int            rej;
      int            e;
      bit            acc;
      for (int k = 0; k < N; k++) b[k] = CW'(k / 2);
      forced1 = 1'b0;
`ifdef FIXED_LAYOUT_EN
      dedge = 1;
      l = l0;
      j = 4'd0; t = '0; i = 0; rej = 0; e = 0; acc = 1'b0;
`else
      l = step(step(l0));
      e = 2; i = N - 1; rej = 0; dedge = -1; t = '0;
      while (dedge < 0) begin
         j   = l[3:0];
         acc = 1'b0;
         if (int'(j) <= i) begin
            t = b[i]; b[i] = b[j]; b[j] = t;
            acc = 1'b1;
         end else if (rej == 3) begin
            acc = 1'b1;
            if (i == 1) forced1 = 1'b1;
         end else begin
            rej++;
         end
         if (acc) begin
            if (i == 1) dedge = e;
            else begin
               i--;
               rej = 0;
            end
         end
         l = step(l);
         e++;
      end
`endif
      for (int k = 0; k < N; k++) lay[k*CW +: CW] = b[k];
   endfunction

   function automatic bit pairs_ok(input logic [LW-1:0] v);
      int cnt [8];
      logic [CW-1:0] c;
      for (int k = 0; k < 8; k++) cnt[k] = 0;
      for (int k = 0; k < N; k++) begin
         c = v[k*CW +: CW];
         cnt[c]++;
      end
      for (int k = 0; k < 8; k++) if (cnt[k] != 2) return 1'b0;
      return 1'b1;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One full request/answer handshake, optionally holding the request
   task automatic do_request(input int gap, input int hold);
      logic [LW-1:0] lay;
      logic [LW-1:0] snap;
      int            de;
      int            got;
      bit            f;
      bit            stable;
      exp_t          x;
      repeat (gap) @(negedge clk);
      model(m_lfsr, lay, de, f);
      sb.push_back('{layout: lay, done_edge: de});
      en  = 1'b1;
      got = -1;
      for (int k = 0; k <= 70; k++) begin
         @(posedge clk); #1;
         if (done) begin
            got = k;
            break;
         end
      end
      x = sb.pop_front();
      if (got < 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no compute_done within 70 edges, expected edge %0d", x.done_edge);
      end else begin
         check("done_edge", 64'(got), 64'(x.done_edge));
         check("layout", 64'(colors), 64'(x.layout));
         check("pairs", 64'(pairs_ok(colors)), 64'd1);
         if (hold > 0) begin
            snap   = colors;
            stable = 1'b1;
            repeat (hold) begin
               @(negedge clk);
               if (!done || colors !== snap) stable = 1'b0;
            end
            check("hold_stable", 64'(stable), 64'd1);
         end
      end
      @(negedge clk);
      en = 1'b0;
      @(posedge clk); #1;
      check("done_drop", 64'(done), 64'd0);
   endtask

`ifndef FIXED_LAYOUT_EN
   // Drop the request five attempts into SHUFFLE and watch for a stray done
   task automatic do_abort();
      logic [LW-1:0] snap;
      bit            pulse;
      bit            stable;
      @(negedge clk);
      en = 1'b1;
      repeat (7) @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      @(posedge clk); #1;
      snap   = colors;
      pulse  = done;
      stable = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (done) pulse = 1'b1;
         if (colors !== snap) stable = 1'b0;
      end
      check("abort_no_done", 64'(pulse), 64'd0);
      check("abort_pairs", 64'(pairs_ok(colors)), 64'd1);
      check("abort_stable", 64'(stable), 64'd1);
   endtask
`endif

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [6];
      bit   found;
      logic [LW-1:0] lay;
      int   de;
      bit   f;
      tbl[0] = '{gap: 0,  hold: 0};
      tbl[1] = '{gap: 3,  hold: 200};
      tbl[2] = '{gap: 17, hold: 2};
      tbl[3] = '{gap: 1,  hold: 0};
      tbl[4] = '{gap: 40, hold: 5};
      tbl[5] = '{gap: 7,  hold: 0};

      rst = 1'b1;
      en  = 1'b0;
      #1;
      check("reset_done", 64'(done), 64'd0);
      check("reset_colors", 64'(colors), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // First request right after reset pins the LFSR seed/sequence
      do_request(0, 0);

      for (int v = 0; v < 6; v++) do_request(tbl[v].gap, tbl[v].hold);

      // Asynchronous reset mid-cycle while holding a finished layout
      @(negedge clk);
      en = 1'b1;
      repeat (70) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_done", 64'(done), 64'd0);
      check("async_rst_colors", 64'(colors), 64'd0);
      @(negedge clk);
      en  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      do_request(0, 0);

`ifndef FIXED_LAYOUT_EN
      do_abort();
      do_request(2, 0);

      // Wait for an LFSR phase that forces the last position to accept
      found = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         model(m_lfsr, lay, de, f);
         if (f) begin
            found = 1'b1;
            break;
         end
      end
      check("forced_found", 64'(found), 64'd1);
      if (found) do_request(0, 0);
`endif

      for (int t = 0; t < 300; t++) do_request(int'($urandom_range(0, 40)), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
